// File: rtl/rr_onehot_sel.sv
// ---------------------------------------------------------------------------
// rr_onehot_sel
//
// Purpose:
//   Round-robin grant generator that drives the select input of an N:1
//   one-hot-select mux. The registered select is always all-zero or exactly
//   one-hot. A grant is held until the owner signals done or drops its
//   request (or, optionally, exceeds its hold budget). Ownership then passes
//   fairly to the next requester, with no idle bubble.
//
// Optional feature:
//   RR_HOLD_TIMEOUT_EN - when defined, a grant is forcibly released after
//   HOLD_MAX cycles, and timeout_o pulses for one cycle on that release.
//   When undefined, timeout_o is tied low and grants persist until done or
//   until the request drops.
//
// Parameters:
//   N        - number of requesters / mux inputs (2..16)
//   HOLD_MAX - maximum grant length in cycles when the timeout is enabled (1..255)
//
// Ports:
//   clk_i       - rising-edge clock
//   rst_ni      - asynchronous active-low reset
//   req_i       - level-sensitive request per mux input
//   done_i      - current owner finished (ignored while idle)
//   sel_o       - registered one-hot mux select, zero when nothing is granted
//   sel_valid_o - high when sel_o is non-zero
//   grant_id_o  - binary index of the set bit of sel_o, zero when idle
//   timeout_o   - one-cycle pulse on a forced (timeout) release
// ---------------------------------------------------------------------------
module rr_onehot_sel #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req_i,
  input  logic                 done_i,
  output logic [N-1:0]         sel_o,
  output logic                 sel_valid_o,
  output logic [$clog2(N)-1:0] grant_id_o,
  output logic                 timeout_o
);

  localparam int IW = $clog2(N);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    sel_q, sel_d;
  logic [IW-1:0]   id_q, id_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            valid_q, valid_d;

  logic [N-1:0]    others;
  logic            ownerReq;
  logic            relTmo;
  logic            release_w;
  logic [IW-1:0]   win;

  // The search visits (last+1), (last+2), ... wrapping modulo N. The loop
  // runs from the farthest candidate to the nearest one so that the nearest
  // set bit is assigned last and therefore wins, without needing a break.
  function automatic logic [IW-1:0] rrWinner(input logic [N-1:0] r,
                                             input logic [IW-1:0] last);
    logic [IW-1:0] w;
    int            idx;
    w = last;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (r[idx]) w = IW'(idx);
    end
    return w;
  endfunction

  function automatic logic [N-1:0] oneHot(input logic [IW-1:0] i);
    logic [N-1:0] o;
    o    = '0;
    o[i] = 1'b1;
    return o;
  endfunction

`ifdef RR_HOLD_TIMEOUT_EN
  localparam int HW = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);

  logic [HW-1:0] hold_q, hold_d;
  logic          tmo_q, tmo_d;

  assign relTmo = (state_q == GRANT) && (hold_q == HOLD_LIM);
`else
  assign relTmo = 1'b0;
`endif

  // While granted, sel_q is exactly the owner's bit, so masking with it
  // removes the owner from the handover search.
  assign others    = req_i & ~sel_q;
  assign ownerReq  = req_i[id_q];
  assign release_w = done_i || !ownerReq || relTmo;

  // The winner search starts after ptr_q. During a grant ptr_q equals the
  // owner, so this is the fair "next after owner" search; in IDLE it is the
  // next after the last grant.
  assign win = rrWinner((state_q == IDLE) ? req_i : others, ptr_q);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
`ifdef RR_HOLD_TIMEOUT_EN
    hold_d  = hold_q;
    tmo_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = GRANT;
          sel_d   = oneHot(win);
          id_d    = win;
          ptr_d   = win;
`ifdef RR_HOLD_TIMEOUT_EN
          hold_d  = HW'(1);
`endif
        end
      end
      GRANT: begin
        if (release_w) begin
`ifdef RR_HOLD_TIMEOUT_EN
          tmo_d = relTmo;
`endif
          if (|others) begin
            sel_d  = oneHot(win);
            id_d   = win;
            ptr_d  = win;
`ifdef RR_HOLD_TIMEOUT_EN
            hold_d = HW'(1);
`endif
          end else if (ownerReq) begin
            // The owner still requests, so this release came from done or
            // timeout: the sole requester keeps the grant with a fresh budget.
`ifdef RR_HOLD_TIMEOUT_EN
            hold_d = HW'(1);
`endif
          end else begin
            state_d = IDLE;
            sel_d   = '0;
            id_d    = '0;
`ifdef RR_HOLD_TIMEOUT_EN
            hold_d  = '0;
`endif
          end
        end else begin
`ifdef RR_HOLD_TIMEOUT_EN
          hold_d = hold_q + HW'(1);
`endif
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        id_d    = '0;
      end
    endcase
    valid_d = |sel_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      id_q    <= '0;
      ptr_q   <= IW'(N - 1);
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

`ifdef RR_HOLD_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      tmo_q  <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign sel_o       = sel_q;
  assign sel_valid_o = valid_q;
  assign grant_id_o  = id_q;

endmodule

// File: tb/tb_rr_onehot_sel.sv
// ---------------------------------------------------------------------------
// tb_rr_onehot_sel
//
// Self-checking bench for rr_onehot_sel (N=4, HOLD_MAX=3). It runs a
// directed vector table, a reset-during-grant sequence, a hold-timeout
// sequence (expectations depend on RR_HOLD_TIMEOUT_EN), and a randomized run
// compared against a behavioural model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_rr_onehot_sel;

  localparam int N        = 4;
  localparam int HOLD_MAX = 3;

`ifdef RR_HOLD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic         clk_i  = 1'b0;
  logic         rst_ni = 1'b0;
  logic [N-1:0] req_i  = '0;
  logic         done_i = 1'b0;
  logic [N-1:0] sel_o;
  logic         sel_valid_o;
  logic [1:0]   grant_id_o;
  logic         timeout_o;

  int total  = 0;
  int passed = 0;

  // Model state: owner index (-1 when idle), last-grant pointer, cycles held.
  int mOwner;
  int mPtr;
  int mHold;
  bit mTmo;

  typedef struct {
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] expSel;
  } vec_t;

  vec_t vecs[23];

  rr_onehot_sel #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .done_i     (done_i),
    .sel_o      (sel_o),
    .sel_valid_o(sel_valid_o),
    .grant_id_o (grant_id_o),
    .timeout_o  (timeout_o)
  );

  // Free-running clock with a 10 ns period.
  always #5 clk_i = ~clk_i;

  // Return the first set request after 'last', wrapping around, or -1.
  function automatic int searchFrom(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mOwner = -1;
    mPtr   = N - 1;
    mHold  = 0;
    mTmo   = 1'b0;
  endtask

  // Advance the model by one clock edge, given the inputs seen at that edge.
  task automatic modelStep(input logic [N-1:0] r, input logic d);
    logic [N-1:0] rest;
    bit           relA, relB, relC;
    int           w;
    mTmo = 1'b0;
    if (mOwner < 0) begin
      w = searchFrom(r, mPtr);
      if (w >= 0) begin
        mOwner = w;
        mPtr   = w;
        mHold  = 1;
      end
    end else begin
      relA = d;
      relB = !r[mOwner];
      relC = TMO_EN && (mHold == HOLD_MAX);
      if (relA || relB || relC) begin
        mTmo = relC;
        rest = r;
        rest[mOwner] = 1'b0;
        w = searchFrom(rest, mOwner);
        if (w >= 0) begin
          mOwner = w;
          mPtr   = w;
          mHold  = 1;
        end else if (r[mOwner]) begin
          mHold = 1;
        end else begin
          mOwner = -1;
          mHold  = 0;
        end
      end else begin
        mHold = mHold + 1;
      end
    end
  endtask

  // Compare all outputs against an expected select and timeout value.
  task automatic checkOutput(input string name, input logic [N-1:0] expSel,
                             input logic expTmo);
    logic [1:0] expId;
    expId = '0;
    for (int i = 0; i < N; i++) if (expSel[i]) expId = 2'(i);
    total++;
    if (sel_o === expSel && sel_valid_o === (|expSel) &&
        grant_id_o === expId && timeout_o === expTmo) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got sel=%b valid=%b id=%0d tmo=%b, expected sel=%b valid=%b id=%0d tmo=%b",
               name, sel_o, sel_valid_o, grant_id_o, timeout_o,
               expSel, |expSel, expId, expTmo);
    end
  endtask

  task automatic checkModel(input string name);
    logic [N-1:0] expSel;
    expSel = '0;
    if (mOwner >= 0) expSel[mOwner] = 1'b1;
    checkOutput(name, expSel, mTmo);
  endtask

  // Drive inputs just after an edge, clock once, sample 1 ns after the edge.
  task automatic applyStimulus(input logic [N-1:0] r, input logic d);
    req_i  = r;
    done_i = d;
    @(posedge clk_i);
    #1;
    modelStep(r, d);
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    req_i  = '0;
    done_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    modelReset();
  endtask

  // Main sequence: directed table, reset-during-grant, timeout, random.
  initial begin
    logic [N-1:0] r;
    logic [N-1:0] tmoSel[7];
    logic         tmoPulse[7];

    vecs[0]  = '{4'b0000, 1'b0, 4'b0000};
    vecs[1]  = '{4'b0000, 1'b0, 4'b0000};
    vecs[2]  = '{4'b0000, 1'b0, 4'b0000};
    vecs[3]  = '{4'b1111, 1'b0, 4'b0001};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0010};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0100};
    vecs[6]  = '{4'b1111, 1'b1, 4'b1000};
    vecs[7]  = '{4'b1111, 1'b1, 4'b0001};
    vecs[8]  = '{4'b1000, 1'b0, 4'b1000};
    vecs[9]  = '{4'b0010, 1'b0, 4'b0010};
    vecs[10] = '{4'b0000, 1'b0, 4'b0000};
    vecs[11] = '{4'b0100, 1'b0, 4'b0100};
    vecs[12] = '{4'b0100, 1'b1, 4'b0100};
    vecs[13] = '{4'b0100, 1'b0, 4'b0100};
    vecs[14] = '{4'b0100, 1'b1, 4'b0100};
    vecs[15] = '{4'b0000, 1'b0, 4'b0000};
    vecs[16] = '{4'b0000, 1'b1, 4'b0000};
    vecs[17] = '{4'b0011, 1'b1, 4'b0001};
    vecs[18] = '{4'b0011, 1'b0, 4'b0001};
    vecs[19] = '{4'b0011, 1'b1, 4'b0010};
    vecs[20] = '{4'b1001, 1'b0, 4'b1000};
    vecs[21] = '{4'b1001, 1'b1, 4'b0001};
    vecs[22] = '{4'b0000, 1'b0, 4'b0000};

    #2;
    checkOutput("reset_state", 4'b0000, 1'b0);
    doReset();

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].req, vecs[i].done);
      checkOutput($sformatf("vec%0d", i), vecs[i].expSel, 1'b0);
    end

    // Reset asserted between edges must clear a live grant at once.
    applyStimulus(4'b0010, 1'b0);
    checkOutput("pre_reset_grant", 4'b0010, 1'b0);
    #3;
    rst_ni = 1'b0;
    #1;
    checkOutput("async_reset_clear", 4'b0000, 1'b0);
    @(posedge clk_i);
    #1;
    checkOutput("held_in_reset", 4'b0000, 1'b0);
    rst_ni = 1'b1;
    modelReset();
    applyStimulus(4'b0110, 1'b0);
    checkOutput("first_after_reset", 4'b0010, 1'b0);

    // Two requesters, no done: timeout alternates them every HOLD_MAX cycles;
    // without the feature the first owner keeps the grant.
    doReset();
    if (TMO_EN) begin
      tmoSel   = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
      tmoPulse = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    end else begin
      tmoSel   = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
      tmoPulse = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    end
    for (int i = 0; i < 7; i++) begin
      applyStimulus(4'b0011, 1'b0);
      checkOutput($sformatf("hold%0d", i), tmoSel[i], tmoPulse[i]);
    end

    // Randomized traffic: requests mostly persist, done fires occasionally.
    doReset();
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
      applyStimulus(r, ($urandom_range(0, 3) == 0));
      checkModel($sformatf("rand%0d", i));
      total++;
      if ($countones(sel_o) <= 1) passed++;
      else $display("[TB] FAIL onehot%0d: sel=%b has %0d bits, required at most 1",
                    i, sel_o, $countones(sel_o));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
